// File: rtl/alu_pkg.sv
// +----------------------------------------------------------------------------+
// | Module : alu_pkg                                                           |
// | Shared widths, opcode constants and CDB lane layout for the ALU slice.     |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

  localparam int TAG_W      = 4;
  localparam int DATA_W     = 32;
  localparam int OP_W       = 6;
  localparam int CDB_LANE_W = 1 + TAG_W + DATA_W;
  localparam int ENTRY_W    = TAG_W + DATA_W;

  localparam logic [OP_W-1:0] OP_ADD    = 6'd0;
  localparam logic [OP_W-1:0] OP_SUB    = 6'd1;
  localparam logic [OP_W-1:0] OP_AND    = 6'd2;
  localparam logic [OP_W-1:0] OP_OR     = 6'd3;
  localparam logic [OP_W-1:0] OP_XOR    = 6'd4;
  localparam logic [OP_W-1:0] OP_SLL    = 6'd5;
  localparam logic [OP_W-1:0] OP_SRL    = 6'd6;
  localparam logic [OP_W-1:0] OP_SRA    = 6'd7;
  localparam logic [OP_W-1:0] OP_SLT    = 6'd8;
  localparam logic [OP_W-1:0] OP_SLTU   = 6'd9;
  localparam logic [OP_W-1:0] OP_EQ     = 6'd10;
  localparam logic [OP_W-1:0] OP_NE     = 6'd11;
  localparam logic [OP_W-1:0] OP_LT     = 6'd12;
  localparam logic [OP_W-1:0] OP_GE     = 6'd13;
  localparam logic [OP_W-1:0] OP_LTU    = 6'd14;
  localparam logic [OP_W-1:0] OP_GEU    = 6'd15;
  localparam logic [OP_W-1:0] OP_MUL    = 6'd16;
  localparam logic [OP_W-1:0] OP_MULH   = 6'd17;
  localparam logic [OP_W-1:0] OP_MULHSU = 6'd18;
  localparam logic [OP_W-1:0] OP_MULHU  = 6'd19;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] value;
  } cdb_lane_t;

endpackage

`default_nettype wire

// File: rtl/alu_if.sv
// +----------------------------------------------------------------------------+
// | Module : alu_if                                                            |
// | Issue port from the reservation station and CDB lane toward the arbiter.  |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

interface alu_if;
  import alu_pkg::*;

  logic                  alu_ready;
  logic [OP_W-1:0]       alu_oprand;
  logic [DATA_W-1:0]     a;
  logic [DATA_W-1:0]     b;
  logic [TAG_W-1:0]      alu_tag;
  logic                  cdb_grant;
  logic                  alu_full;
  logic [CDB_LANE_W-1:0] cdb_out;
  logic                  overflow;

  modport slave (
    input  alu_ready, alu_oprand, a, b, alu_tag, cdb_grant,
    output alu_full, cdb_out, overflow
  );

  modport master (
    output alu_ready, alu_oprand, a, b, alu_tag, cdb_grant,
    input  alu_full, cdb_out, overflow
  );

endinterface

`default_nettype wire

// File: rtl/alu_result_fifo.sv
// +----------------------------------------------------------------------------+
// | Module : alu_result_fifo                                                   |
// | Result queue with a registered head; a pushed entry shows one edge later.  |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_result_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 36
) (
  input  wire logic                       clk,
  input  wire logic                       rst_n,
  input  wire logic                       flush_i,
  input  wire logic                       push_i,
  input  wire logic [W-1:0]               data_i,
  input  wire logic                       pop_i,
  output logic                            full_o,
  output logic                            empty_o,
  output logic [$clog2(DEPTH):0]          count_o,
  output logic                            head_valid_o,
  output logic [W-1:0]                    head_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             head_valid_q, head_valid_d;
  logic [W-1:0]     head_q, head_d;

  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic [CNT_W-1:0] w_remain;

  assign w_full   = (count_q == CNT_W'(DEPTH));
  assign w_pop    = pop_i && head_valid_q;
  assign w_push   = push_i && (!w_full || w_pop);
  // Entries that were already stored before this edge and survive the pop;
  // only those may be shown, which gives the extra cycle of visibility delay.
  assign w_remain = count_q - CNT_W'(w_pop);

  always_comb begin
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    head_valid_d = 1'b0;
    head_d       = '0;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + PTR_W'(w_pop);
      wr_ptr_d = wr_ptr_q + PTR_W'(w_push);
      count_d  = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
      if (w_remain != '0) begin
        head_valid_d = 1'b1;
        head_d       = mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      head_valid_q <= 1'b0;
      head_q       <= '0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      head_valid_q <= head_valid_d;
      head_q       <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !flush_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign full_o       = w_full;
  assign empty_o      = (count_q == '0);
  assign count_o      = count_q;
  assign head_valid_o = head_valid_q;
  assign head_o       = head_q;

endmodule

`default_nettype wire

// File: rtl/alu_unit.sv
// +----------------------------------------------------------------------------+
// | Module : alu_unit                                                          |
// | Two-stage ALU feeding a CDB result queue. Macro ALU_MUL_EN adds opcodes    |
// | 16-19 (MUL/MULH/MULHSU/MULHU); without it those opcodes return zero.       |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_unit
  import alu_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic flush,
  alu_if.slave      bus
);

  localparam int CNT_W = $clog2(QDEPTH) + 1;

  logic              s1_valid_q, s1_valid_d;
  logic [OP_W-1:0]   s1_op_q,    s1_op_d;
  logic [DATA_W-1:0] s1_a_q,     s1_a_d;
  logic [DATA_W-1:0] s1_b_q,     s1_b_d;
  logic [TAG_W-1:0]  s1_tag_q,   s1_tag_d;
  logic              overflow_q, overflow_d;

  logic              w_issue;
  logic              w_full;
  logic [CNT_W-1:0]  w_count;
  logic [CNT_W-1:0]  w_occupancy;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_head_valid;
  logic [ENTRY_W-1:0] w_head;
  logic [4:0]        w_shamt;
  logic [DATA_W-1:0] w_result;
  cdb_lane_t         w_lane;

  // s1 always drains into the queue next edge, so it is counted as occupancy.
  assign w_occupancy = w_count + CNT_W'(s1_valid_q);
  assign w_full      = w_fifo_full || (w_occupancy >= CNT_W'(QDEPTH));
  assign w_issue     = bus.alu_ready && !w_full && !flush;

  always_comb begin
    s1_valid_d = w_issue;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_tag_d   = s1_tag_q;
    overflow_d = bus.alu_ready && w_full && !flush;
    if (w_issue) begin
      s1_op_d  = bus.alu_oprand;
      s1_a_d   = bus.a;
      s1_b_d   = bus.b;
      s1_tag_d = bus.alu_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_tag_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_tag_q   <= s1_tag_d;
      overflow_q <= overflow_d;
    end
  end

  assign w_shamt = s1_b_q[4:0];

`ifdef ALU_MUL_EN
  logic [63:0] w_prod_ss;
  logic [63:0] w_prod_su;
  logic [63:0] w_prod_uu;

  // 64-bit products of extended operands; the low 64 bits are exact for
  // every signedness combination.
  assign w_prod_ss = {{32{s1_a_q[31]}}, s1_a_q} * {{32{s1_b_q[31]}}, s1_b_q};
  assign w_prod_su = {{32{s1_a_q[31]}}, s1_a_q} * {32'd0, s1_b_q};
  assign w_prod_uu = {32'd0, s1_a_q} * {32'd0, s1_b_q};
`endif

  always_comb begin
    w_result = '0;
    case (s1_op_q)
      OP_ADD:  w_result = s1_a_q + s1_b_q;
      OP_SUB:  w_result = s1_a_q - s1_b_q;
      OP_AND:  w_result = s1_a_q & s1_b_q;
      OP_OR:   w_result = s1_a_q | s1_b_q;
      OP_XOR:  w_result = s1_a_q ^ s1_b_q;
      OP_SLL:  w_result = s1_a_q << w_shamt;
      OP_SRL:  w_result = s1_a_q >> w_shamt;
      OP_SRA:  w_result = $unsigned($signed(s1_a_q) >>> w_shamt);
      OP_SLT,
      OP_LT:   w_result = {31'd0, $signed(s1_a_q) <  $signed(s1_b_q)};
      OP_SLTU,
      OP_LTU:  w_result = {31'd0, s1_a_q <  s1_b_q};
      OP_EQ:   w_result = {31'd0, s1_a_q == s1_b_q};
      OP_NE:   w_result = {31'd0, s1_a_q != s1_b_q};
      OP_GE:   w_result = {31'd0, $signed(s1_a_q) >= $signed(s1_b_q)};
      OP_GEU:  w_result = {31'd0, s1_a_q >= s1_b_q};
`ifdef ALU_MUL_EN
      OP_MUL:    w_result = w_prod_uu[31:0];
      OP_MULH:   w_result = w_prod_ss[63:32];
      OP_MULHSU: w_result = w_prod_su[63:32];
      OP_MULHU:  w_result = w_prod_uu[63:32];
`endif
      default: w_result = '0;
    endcase
  end

  assign w_push = s1_valid_q && !flush;
  assign w_pop  = bus.cdb_grant && w_head_valid && !w_fifo_empty && !flush;

  alu_result_fifo #(
    .DEPTH (QDEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush),
    .push_i       (w_push),
    .data_i       ({s1_tag_q, w_result}),
    .pop_i        (w_pop),
    .full_o       (w_fifo_full),
    .empty_o      (w_fifo_empty),
    .count_o      (w_count),
    .head_valid_o (w_head_valid),
    .head_o       (w_head)
  );

  always_comb begin
    w_lane.valid = w_head_valid;
    w_lane.tag   = w_head[ENTRY_W-1:DATA_W];
    w_lane.value = w_head[DATA_W-1:0];
  end

  assign bus.alu_full = w_full;
  assign bus.cdb_out  = w_lane;
  assign bus.overflow = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_unit.sv
// +----------------------------------------------------------------------------+
// | Module : tb_alu_unit                                                       |
// | Scoreboard bench for alu_unit (honours ALU_MUL_EN like the design).        |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_alu_unit;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  logic flush;
  int   n_checks;
  int   n_fail;
  int   valid_seen;
  logic [35:0] exp_q [$];

  alu_if u_if ();

  alu_unit #(.QDEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [5:0] op, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] ext;
    logic [63:0] p;
    int sh;
    sh = int'(y[4:0]);
    case (op)
      6'd0:  return x + y;
      6'd1:  return x - y;
      6'd2:  return x & y;
      6'd3:  return x | y;
      6'd4:  return x ^ y;
      6'd5:  return x << sh;
      6'd6:  return x >> sh;
      6'd7:  begin ext = {{32{x[31]}}, x} >> sh; return ext[31:0]; end
      6'd8, 6'd12: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      6'd9, 6'd14: return (x < y) ? 32'd1 : 32'd0;
      6'd10: return (x == y) ? 32'd1 : 32'd0;
      6'd11: return (x != y) ? 32'd1 : 32'd0;
      6'd13: return ($signed(x) >= $signed(y)) ? 32'd1 : 32'd0;
      6'd15: return (x >= y) ? 32'd1 : 32'd0;
`ifdef ALU_MUL_EN
      6'd16: begin p = 64'(longint'(x) * longint'(y)); return p[31:0]; end
      6'd17: begin p = 64'(longint'($signed(x)) * longint'($signed(y))); return p[63:32]; end
      6'd18: begin p = 64'(longint'($signed(x)) * longint'({32'd0, y})); return p[63:32]; end
      6'd19: begin p = {32'd0, x} * {32'd0, y}; return p[63:32]; end
`endif
      default: return 32'd0;
    endcase
  endfunction

  // Called one time unit after a rising edge; returns one unit after the issue edge.
  task automatic issue(input logic [5:0] op, input logic [31:0] x, input logic [31:0] y,
                       input logic [3:0] tag, input logic [31:0] expv, input bit acc);
    u_if.alu_ready  = 1'b1;
    u_if.alu_oprand = op;
    u_if.a          = x;
    u_if.b          = y;
    u_if.alu_tag    = tag;
    #1;
    check_eq("full_at_issue", 64'(u_if.alu_full), 64'(!acc));
    if (acc) exp_q.push_back({tag, expv});
    @(posedge clk);
    #1;
    u_if.alu_ready = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 60) begin
      tick(1);
      k++;
    end
    check_eq(tag, 64'(exp_q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && !flush && u_if.cdb_out[36]) begin
      valid_seen++;
      if (u_if.cdb_grant) begin
        if (exp_q.size() == 0) check_eq("cdb_unexpected", 64'(u_if.cdb_out), 64'd0);
        else check_eq("cdb_result", 64'(u_if.cdb_out[35:0]), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb;
    n_checks = 0; n_fail = 0; valid_seen = 0;
    rst_n = 1'b0; flush = 1'b0;
    u_if.alu_ready = 1'b0; u_if.alu_oprand = '0; u_if.a = '0; u_if.b = '0;
    u_if.alu_tag = '0; u_if.cdb_grant = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_cdb", 64'(u_if.cdb_out), 64'd0);
    check_eq("rst_full", 64'(u_if.alu_full), 64'd0);
    check_eq("rst_ovf", 64'(u_if.overflow), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Latency: valid exactly one cycle, two edges after the issue edge.
    u_if.cdb_grant = 1'b1;
    issue(OP_ADD, 32'd5, 32'd7, 4'd3, 32'd12, 1'b1);
    check_eq("lat_e0", 64'(u_if.cdb_out[36]), 64'd0);
    tick(1);
    check_eq("lat_e1", 64'(u_if.cdb_out[36]), 64'd0);
    tick(1);
    check_eq("lat_e2", 64'(u_if.cdb_out), {27'd0, 1'b1, 4'd3, 32'd12});
    tick(1);
    check_eq("lat_e3", 64'(u_if.cdb_out[36]), 64'd0);

    // Boundary values with hand-derived expectations.
    issue(OP_SRA,  32'h80000000, 32'h21, 4'd1, 32'hC0000000, 1'b1);
    issue(OP_SLTU, 32'd1, 32'hFFFFFFFF, 4'd2, 32'd1, 1'b1);
    issue(OP_SUB,  32'd0, 32'd1, 4'd4, 32'hFFFFFFFF, 1'b1);
    issue(OP_ADD,  32'hFFFFFFFF, 32'd2, 4'd5, 32'd1, 1'b1);
    issue(6'd63,   32'h1234, 32'h5678, 4'd6, 32'd0, 1'b1);
`ifdef ALU_MUL_EN
    issue(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd7, 32'hFFFFFFFE, 1'b1);
`else
    issue(OP_MUL,   32'd3, 32'd4, 4'd7, 32'd0, 1'b1);
`endif
    // Every opcode back-to-back with mixed operands.
    for (int i = 0; i < 24; i++) begin
      ra = (i % 3 == 0) ? 32'h80000000 | $urandom : $urandom;
      rb = (i % 4 == 0) ? ra : ((i % 4 == 1) ? $urandom_range(0, 40) : $urandom);
      issue(6'(i), ra, rb, 4'(i), model(6'(i), ra, rb), 1'b1);
    end
    drain("drain_ops");

    // Fill with grant low, overflow on fifth issue, then single pop frees a slot.
    u_if.cdb_grant = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ra = $urandom; rb = $urandom;
      issue(OP_XOR, ra, rb, 4'(8 + i), ra ^ rb, 1'b1);
    end
    check_eq("full_after4", 64'(u_if.alu_full), 64'd1);
    issue(OP_OR, 32'hF0, 32'h0F, 4'd15, 32'hFF, 1'b0);
    check_eq("ovf_pulse", 64'(u_if.overflow), 64'd1);
    tick(1);
    check_eq("ovf_clear", 64'(u_if.overflow), 64'd0);
    check_eq("full_held", 64'(u_if.alu_full), 64'd1);
    u_if.cdb_grant = 1'b1;
    tick(1);
    u_if.cdb_grant = 1'b0;
    check_eq("full_drop", 64'(u_if.alu_full), 64'd0);
    issue(OP_AND, 32'hFF00FF00, 32'h0FF00FF0, 4'd12, 32'h0F000F00, 1'b1);
    u_if.cdb_grant = 1'b1;
    drain("drain_full");

    // Flush with two queued, one in s1 and a same-cycle issue and grant.
    u_if.cdb_grant = 1'b0;
    for (int i = 0; i < 3; i++) issue(OP_ADD, 32'(i), 32'd100, 4'(i), 32'(i + 100), 1'b1);
    flush = 1'b1;
    u_if.alu_ready = 1'b1; u_if.alu_oprand = OP_ADD; u_if.a = 32'd1; u_if.b = 32'd1;
    u_if.cdb_grant = 1'b1;
    tick(1);
    flush = 1'b0; u_if.alu_ready = 1'b0;
    exp_q.delete();
    check_eq("flush_cdb", 64'(u_if.cdb_out[36]), 64'd0);
    check_eq("flush_full", 64'(u_if.alu_full), 64'd0);
    valid_seen = 0;
    tick(8);
    check_eq("flush_quiet", 64'(valid_seen), 64'd0);

    // Asynchronous reset mid-operation discards the queued result.
    issue(OP_SLL, 32'd1, 32'd4, 4'd9, 32'd16, 1'b1);
    tick(1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_cdb", 64'(u_if.cdb_out), 64'd0);
    check_eq("arst_full", 64'(u_if.alu_full), 64'd0);
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;
    valid_seen = 0;
    tick(6);
    check_eq("arst_quiet", 64'(valid_seen), 64'd0);

    // Post-reset sanity.
    issue(OP_GE, 32'hFFFFFFFF, 32'd0, 4'd10, 32'd0, 1'b1);
    issue(OP_GEU, 32'hFFFFFFFF, 32'd0, 4'd11, 32'd1, 1'b1);
    drain("drain_post");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_unit.md
ALU_UNIT -- requirements
Module: alu_unit

Interface
REQ-001 SHALL have parameter: QDEPTH, 4, result-queue entries (power of two, >=2).
REQ-002 SHALL have port: clk  in  1  rising-edge clock.
REQ-003 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: flush  in  1  discard all in-flight work.
REQ-005 SHALL have port: alu_ready  in  1  issue valid from reservation station.
REQ-006 SHALL have port: alu_oprand  in  6  opcode.
REQ-007 SHALL have port: a  in  32  operand A.
REQ-008 SHALL have port: b  in  32  operand B.
REQ-009 SHALL have port: alu_tag  in  4  destination tag.
REQ-010 SHALL have port: cdb_grant  in  1  CDB arbiter consumed cdb_out this cycle.
REQ-011 SHALL have port: alu_full  out  1  issue backpressure.
REQ-012 SHALL have port: cdb_out  out  37  CDB lane {valid[36], tag[35:32], value[31:0]}.
REQ-013 SHALL have port: overflow  out  1  one-cycle pulse, issue dropped.

Function
REQ-014 SHALL sample an issue when alu_ready=1 and alu_full=0 into stage-1 register (s1).
REQ-015 SHALL compute on s1 and push {tag,result} into result queue at the next edge.
REQ-016 SHALL present queue head on cdb_out; cdb_out[36]=1 iff queue non-empty; latency issue-edge E0 -> valid after E2.
REQ-017 SHALL pop head on edge where cdb_out[36]=1 and cdb_grant=1; head held stable otherwise.
REQ-018 SHALL drive alu_full combinationally = (count + s1_valid) >= QDEPTH.
REQ-019 SHALL drop an issue arriving with alu_full=1 and pulse overflow for one cycle.
REQ-020 SHALL accept simultaneous push and pop when queue full; count unchanged.
REQ-021 SHALL decode opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 EQ, 11 NE, 12 LT, 13 GE, 14 LTU, 15 GEU.
REQ-022 SHALL use b[4:0] as shift amount; ADD/SUB wrap modulo 2^32; compare ops return 32'd1/32'd0.
REQ-023 SHALL return 0 for any undefined opcode, tag preserved.
REQ-024 SHALL, on flush=1, clear s1 and queue at that edge; same-cycle issue and grant ignored; cdb_out[36]=0 next cycle.
REQ-025 SHALL wrap queue pointers modulo QDEPTH.

Reset
REQ-026 SHALL on rst_n=0 immediately clear s1_valid, queue pointers, count, cdb_out (all 37 bits), overflow; alu_full=0.
REQ-027 SHALL discard any in-flight result when reset asserts mid-operation.

Configuration
REQ-028 SHALL honour macro ALU_MUL_EN: defined -> opcodes 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU computed in stage 2, same latency; undefined -> opcodes 16-19 return 0 as undefined.

Structure
REQ-029 SHALL place opcode constants, TAG_W=4, CDB_LANE_W=37 in shared package alu_pkg.
REQ-030 SHALL implement queue as sub-module alu_result_fifo (push/pop/full/empty/count).

Verification
REQ-031 ADD a=5,b=7,tag=3, grant held 1 -> cdb_out=valid,tag 3,value 12 two cycles after issue, one cycle only.
REQ-032 SRA a=32'h80000000,b=32'h21 -> value 32'hC0000000 (shift 1); SLTU a=1,b=32'hFFFFFFFF -> 1.
REQ-033 grant=0, issue 4 ops (QDEPTH=4) -> alu_full=1 after 4th accepted; 5th issue -> overflow pulse, dropped; release grant -> 4 results in issue order.
REQ-034 queue full, issue blocked, grant=1 one cycle -> head popped, alu_full drops, next issue accepted.
REQ-035 flush with 2 queued + 1 in s1 and same-cycle issue -> cdb_out[36]=0 next cycle, no later result appears.
REQ-036 ALU_MUL_EN defined: MULHU a=b=32'hFFFFFFFF -> 32'hFFFFFFFE; undefined: opcode 16 -> 0.
